latch_write_sequencer: RTL and testbench

//  Upstream driver for the D_latch stage. Debounces a raw asynchronous level input
//  and, on request, produces a clean D value and a timed enable pulse for the latch.
//  D is set up one cycle before enable rises and held one cycle after enable falls.

---
 rtl/latch_write_sequencer_pkg.sv | 26 ++
 rtl/latch_write_sequencer_debounce_filter.sv | 47 ++++
 rtl/latch_write_sequencer.sv | 110 +++++++++++
 tb/tb_latch_write_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/latch_write_sequencer_pkg.sv
// Shared definitions for the latch write sequencer: write FSM encodings,
// default parameter values and the registered latch-drive bundle.
package latch_write_sequencer_pkg;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
  localparam int unsigned DEF_DB_CNT_WIDTH    = 4;
  localparam int unsigned DEF_EN_PULSE_CYCLES = 2;
  localparam int unsigned PULSE_CNT_WIDTH     = 4;
  localparam int unsigned STATE_WIDTH         = 2;

  typedef enum logic [STATE_WIDTH-1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_PULSE = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  // Everything the sequencer presents to the latch, registered together.
  typedef struct packed {
    logic d;
    logic enable;
    logic busy;
    logic done;
  } latch_drive_t;

endpackage

// File: rtl/latch_write_sequencer_debounce_filter.sv
// Two-flop synchroniser followed by a run-length debounce: clean_out only follows the
// synchronised level after it has differed for DEBOUNCE_CYCLES consecutive cycles.
module latch_write_sequencer_debounce_filter
  import latch_write_sequencer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned DB_CNT_WIDTH    = DEF_DB_CNT_WIDTH
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic clean_out
);

  logic                    sync_meta;
  logic                    sync_q;
  logic [DB_CNT_WIDTH-1:0] cnt_q;
  logic                    cnt_last;

  assign cnt_last = (cnt_q == DB_CNT_WIDTH'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      sync_meta <= raw_in;
      sync_q    <= sync_meta;
    end
  end

  // The update fires on the edge where the run length would reach DEBOUNCE_CYCLES.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      clean_out <= 1'b0;
    end else if (sync_q == clean_out) begin
      cnt_q <= '0;
    end else if (cnt_last) begin
      cnt_q     <= '0;
      clean_out <= sync_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/latch_write_sequencer.sv
// Drives a downstream D latch: debounces raw_in, then on load_req snapshots the clean level
// into D and issues SETUP / enable PULSE / HOLD so D brackets the enable pulse by one cycle.
module latch_write_sequencer
  import latch_write_sequencer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned DB_CNT_WIDTH    = DEF_DB_CNT_WIDTH,
  parameter int unsigned EN_PULSE_CYCLES = DEF_EN_PULSE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  input  logic load_req,
  output logic clean_out,
  output logic D,
  output logic enable,
  output logic busy,
  output logic done
);

  state_t                     state_q;
  state_t                     state_d;
  logic [PULSE_CNT_WIDTH-1:0] pulse_cnt_q;
  logic [PULSE_CNT_WIDTH-1:0] pulse_cnt_d;
  logic                       pulse_last;
  latch_drive_t               drive_q;
  latch_drive_t               drive_d;

  latch_write_sequencer_debounce_filter #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .DB_CNT_WIDTH    (DB_CNT_WIDTH)
  ) u_debounce (
    .clk       (clk),
    .reset     (reset),
    .raw_in    (raw_in),
    .clean_out (clean_out)
  );

  assign pulse_last = (pulse_cnt_q == PULSE_CNT_WIDTH'(EN_PULSE_CYCLES - 1));

  // State, pulse counter and output registers; reset kills enable immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pulse_cnt_q <= '0;
      drive_q     <= '0;
    end else begin
      state_q     <= state_d;
      pulse_cnt_q <= pulse_cnt_d;
      drive_q     <= drive_d;
    end
  end

  // HOLD accepts a pending request so back-to-back writes repeat every 2+EN_PULSE_CYCLES cycles.
  always_comb begin
    state_d     = state_q;
    pulse_cnt_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (load_req) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        state_d = ST_PULSE;
      end
      ST_PULSE: begin
        if (pulse_last) begin
          state_d = ST_HOLD;
        end else begin
          pulse_cnt_d = pulse_cnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        state_d = load_req ? ST_SETUP : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from the next state so they register in step with it.
  // Entering SETUP is the only point D may change; it takes clean_out before any same-edge update.
  always_comb begin
    drive_d   = '0;
    drive_d.d = drive_q.d;
    case (state_d)
      ST_SETUP: begin
        drive_d.d    = clean_out;
        drive_d.busy = 1'b1;
      end
      ST_PULSE: begin
        drive_d.enable = 1'b1;
        drive_d.busy   = 1'b1;
      end
      ST_HOLD: begin
        drive_d.busy = 1'b1;
        drive_d.done = 1'b1;
      end
      default: begin
        drive_d.enable = 1'b0;
      end
    endcase
  end

  assign D      = drive_q.d;
  assign enable = drive_q.enable;
  assign busy   = drive_q.busy;
  assign done   = drive_q.done;

endmodule

// File: tb/tb_latch_write_sequencer.sv
// Directed bench for latch_write_sequencer driving a behavioural D latch
// (DEBOUNCE_CYCLES=4, EN_PULSE_CYCLES=2).
module tb_latch_write_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic raw_in = 1'b0;
  logic load_req = 1'b0;
  logic clean_out;
  logic d_out;
  logic enable;
  logic busy;
  logic done;
  logic q = 1'b0;
  logic q_bar;

  int errors = 0;
  int checks = 0;

  latch_write_sequencer #(
    .DEBOUNCE_CYCLES (4),
    .DB_CNT_WIDTH    (4),
    .EN_PULSE_CYCLES (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .raw_in    (raw_in),
    .load_req  (load_req),
    .clean_out (clean_out),
    .D         (d_out),
    .enable    (enable),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Transparent-high D latch standing in for the downstream stage.
  always @(enable or d_out) begin
    if (enable) q = d_out;
  end
  assign q_bar = ~q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1: reset asserted mid-cycle with arbitrary inputs
    raw_in   = 1'b1;
    load_req = 1'b1;
    #1 reset = 1'b1;
    #1;
    check("rst_clean", clean_out, 1'b0);
    check("rst_d", d_out, 1'b0);
    check("rst_enable", enable, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    repeat (3) tick();
    check("rst_hold_busy", busy, 1'b0);
    check("rst_hold_clean", clean_out, 1'b0);
    raw_in   = 1'b0;
    load_req = 1'b0;
    reset    = 1'b0;
    tick();

    // First write of 0
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    check("w0_d", d_out, 1'b0);
    check("w0_busy", busy, 1'b1);
    repeat (4) tick();
    check("w0_busy_end", busy, 1'b0);
    check("w0_q", q, 1'b0);

    // 2: debounce latency, clean_out rises 6 edges after first sampling edge
    raw_in = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check($sformatf("db_rise_e%0d", i), clean_out, (i == 6) ? 1'b1 : 1'b0);
    end
    repeat (4) tick();
    check("db_rise_hold", clean_out, 1'b1);
    raw_in = 1'b0;
    repeat (8) tick();
    check("db_fall", clean_out, 1'b0);

    // 3-cycle glitch is dropped
    raw_in = 1'b1;
    repeat (3) tick();
    raw_in = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check($sformatf("db_glitch3_e%0d", i), clean_out, 1'b0);
    end

    // 4-cycle run is just long enough to pass
    raw_in = 1'b1;
    repeat (4) tick();
    raw_in = 1'b0;
    tick();
    check("db_run4_e5", clean_out, 1'b0);
    tick();
    check("db_run4_e6", clean_out, 1'b1);
    repeat (10) tick();
    check("db_run4_back", clean_out, 1'b0);

    // 3: normal write of 1
    raw_in = 1'b1;
    repeat (8) tick();
    check("w1_clean", clean_out, 1'b1);
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    check("w1_k_d", d_out, 1'b1);
    check("w1_k_en", enable, 1'b0);
    check("w1_k_busy", busy, 1'b1);
    check("w1_k_done", done, 1'b0);
    tick();
    check("w1_k1_en", enable, 1'b1);
    check("w1_k1_done", done, 1'b0);
    tick();
    check("w1_k2_en", enable, 1'b1);
    check("w1_k2_busy", busy, 1'b1);
    tick();
    check("w1_k3_en", enable, 1'b0);
    check("w1_k3_done", done, 1'b1);
    check("w1_k3_busy", busy, 1'b1);
    tick();
    check("w1_k4_busy", busy, 1'b0);
    check("w1_k4_done", done, 1'b0);
    check("w1_q", q, 1'b1);
    check("w1_q_bar", q_bar, 1'b0);

    // 4: clean_out falls during PULSE and a request arrives mid-sequence
    raw_in = 1'b0;
    repeat (3) tick();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    check("snap_k_d", d_out, 1'b1);
    tick();
    check("snap_k1_en", enable, 1'b1);
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    check("snap_k2_clean", clean_out, 1'b0);
    check("snap_k2_d", d_out, 1'b1);
    check("snap_k2_en", enable, 1'b1);
    tick();
    check("snap_k3_done", done, 1'b1);
    tick();
    check("snap_k4_busy", busy, 1'b0);
    check("snap_k4_d", d_out, 1'b1);
    tick();
    check("snap_k5_busy", busy, 1'b0);

    // load_req on the same edge clean_out rises: snapshot is the old 0
    raw_in = 1'b1;
    repeat (5) tick();
    check("same_edge_pre_clean", clean_out, 1'b0);
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    check("same_edge_clean", clean_out, 1'b1);
    check("same_edge_d", d_out, 1'b0);
    repeat (4) tick();
    check("same_edge_busy", busy, 1'b0);
    check("same_edge_q", q, 1'b0);
    check("same_edge_q_bar", q_bar, 1'b1);

    // 5: back-to-back, load_req held for 10 edges
    load_req = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      tick();
      if (i == 10) load_req = 1'b0;
      check($sformatf("b2b_en_%0d", i), enable, ((i % 4) == 2 || (i % 4) == 3) ? 1'b1 : 1'b0);
      check($sformatf("b2b_done_%0d", i), done, ((i % 4) == 0) ? 1'b1 : 1'b0);
      check($sformatf("b2b_busy_%0d", i), busy, (i <= 12) ? 1'b1 : 1'b0);
    end
    check("b2b_d", d_out, 1'b1);
    check("b2b_q", q, 1'b1);

    // 6: reset while enable is high
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    tick();
    check("rstp_pre_en", enable, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("rstp_en", enable, 1'b0);
    check("rstp_busy", busy, 1'b0);
    check("rstp_d", d_out, 1'b0);
    check("rstp_clean", clean_out, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    check("rstp_idle_busy", busy, 1'b0);
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    check("rstp_k_busy", busy, 1'b1);
    check("rstp_k_en", enable, 1'b0);
    check("rstp_k_d", d_out, 1'b0);
    tick();
    check("rstp_k1_en", enable, 1'b1);
    tick();
    check("rstp_k2_en", enable, 1'b1);
    tick();
    check("rstp_k3_en", enable, 1'b0);
    check("rstp_k3_done", done, 1'b1);
    tick();
    check("rstp_k4_busy", busy, 1'b0);
    check("rstp_k4_done", done, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
